// File: rtl/graphics_painter.sv
// Rectangle painter: solid fill or ROM blit into a 640x480 RGB444 framebuffer, one pixel per cycle.
// Build option GRAPHICS_PAINTER_CLIP_EN clamps the rectangle to the screen and skips empty rectangles.
module graphics_painter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int VRAM_AW = 19,
  parameter int ROM_AW  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gp_en,
  input  logic               gp_opcode,
  input  logic [9:0]         gp_tl_x,
  input  logic [8:0]         gp_tl_y,
  input  logic [9:0]         gp_br_x,
  input  logic [8:0]         gp_br_y,
  input  logic [11:0]        gp_arg,
  output logic               gp_finish,
  output logic               busy,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [11:0]        rom_data,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [11:0]        vram_data
);

`ifdef GRAPHICS_PAINTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic               op_reg;
  logic [9:0]         tl_x_reg, br_x_reg, x_reg;
  logic [8:0]         tl_y_reg, br_y_reg, y_reg;
  logic [11:0]        arg_reg;
  logic [VRAM_AW-1:0] row_base_reg;
  logic [ROM_AW-1:0]  rom_ptr_reg;
  logic               pend_reg;
  logic [VRAM_AW-1:0] pend_addr_reg;

  logic [9:0]         br_x_clip;
  logic [8:0]         br_y_clip;
  logic               empty_rect;
  logic               last_pixel;
  logic [VRAM_AW-1:0] pix_addr;

  // CLIP_EN is a constant, so the clamp logic folds away in the default build
  always_comb begin
    br_x_clip  = (CLIP_EN && (br_x_reg > X_MAX)) ? X_MAX : br_x_reg;
    br_y_clip  = (CLIP_EN && (br_y_reg > Y_MAX)) ? Y_MAX : br_y_reg;
    empty_rect = CLIP_EN && ((tl_x_reg > br_x_clip) || (tl_y_reg > br_y_clip));
  end

  assign last_pixel = (x_reg == br_x_reg) && (y_reg == br_y_reg);
  assign pix_addr   = row_base_reg + VRAM_AW'(x_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gp_en) state_next = LOAD;
      LOAD:    state_next = empty_rect ? DONE : RUN;
      RUN:     if (last_pixel) state_next = op_reg ? DRAIN : DONE;
      DRAIN:   state_next = DONE;
      DONE:    if (!gp_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= 1'b0;
      tl_x_reg      <= '0;
      tl_y_reg      <= '0;
      br_x_reg      <= '0;
      br_y_reg      <= '0;
      arg_reg       <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      row_base_reg  <= '0;
      rom_ptr_reg   <= '0;
      pend_reg      <= 1'b0;
      pend_addr_reg <= '0;
    end else begin
      pend_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gp_en) begin
            op_reg   <= gp_opcode;
            tl_x_reg <= gp_tl_x;
            tl_y_reg <= gp_tl_y;
            br_x_reg <= gp_br_x;
            br_y_reg <= gp_br_y;
            arg_reg  <= gp_arg;
          end
        end
        LOAD: begin
          br_x_reg     <= br_x_clip;
          br_y_reg     <= br_y_clip;
          x_reg        <= tl_x_reg;
          y_reg        <= tl_y_reg;
          row_base_reg <= VRAM_AW'(tl_y_reg) * VRAM_AW'(H_RES);
          rom_ptr_reg  <= ROM_AW'(arg_reg);
        end
        RUN: begin
          // blit writes trail their ROM read by one cycle
          pend_reg      <= op_reg;
          pend_addr_reg <= pix_addr;
          rom_ptr_reg   <= rom_ptr_reg + ROM_AW'(1);
          if (x_reg != br_x_reg) begin
            x_reg <= x_reg + 10'd1;
          end else if (!last_pixel) begin
            x_reg        <= tl_x_reg;
            y_reg        <= y_reg + 9'd1;
            row_base_reg <= row_base_reg + VRAM_AW'(H_RES);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_data = '0;
    rom_addr  = '0;
    if (state_reg == RUN) begin
      if (op_reg) begin
        rom_addr = rom_ptr_reg;
      end else begin
        vram_we   = 1'b1;
        vram_addr = pix_addr;
        vram_data = arg_reg;
      end
    end
    if (pend_reg) begin
      vram_we   = 1'b1;
      vram_addr = pend_addr_reg;
      vram_data = rom_data;
    end
  end

  assign busy      = (state_reg == LOAD) || (state_reg == RUN);
  assign gp_finish = (state_reg == DONE) && gp_en;

endmodule

// File: tb/tb_graphics_painter.sv
// Scoreboard bench for graphics_painter: expected VRAM writes are queued per command and popped by a monitor.
module tb_graphics_painter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gp_en = 1'b0;
  logic        gp_opcode = 1'b0;
  logic [9:0]  gp_tl_x = '0;
  logic [8:0]  gp_tl_y = '0;
  logic [9:0]  gp_br_x = '0;
  logic [8:0]  gp_br_y = '0;
  logic [11:0] gp_arg = '0;
  logic        gp_finish;
  logic        busy;
  logic [16:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [11:0] vram_data;

  graphics_painter dut (
    .clk(clk), .rst_n(rst_n), .gp_en(gp_en), .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
    .gp_arg(gp_arg), .gp_finish(gp_finish), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  issue_cyc = 0;
  int  first_we_cyc = -1;
  bit  first_armed = 1'b0;

  function automatic logic [11:0] rom_val(input logic [16:0] a);
    case (a)
      17'h10:  rom_val = 12'h111;
      17'h11:  rom_val = 12'h222;
      17'h12:  rom_val = 12'h333;
      17'h13:  rom_val = 12'h444;
      default: rom_val = 12'(a * 37 + 5);
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= rom_val(rom_addr);
  end

  // Monitor: every committed write must match the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && vram_we) begin
      wr_count++;
      if (first_armed) begin
        first_we_cyc = cyc;
        first_armed = 1'b0;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_write addr=%0d data=%h expected no write", vram_addr, vram_data);
      end else begin
        e = exp_q.pop_front();
        if (vram_addr !== e.addr || vram_data !== e.data) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   vram_addr, vram_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_rect(input logic op, input int tlx, input int tly, input int brx,
                           input int bry, input logic [11:0] arg);
    int k = 0;
`ifdef GRAPHICS_PAINTER_CLIP_EN
    if (brx > 639) brx = 639;
    if (bry > 479) bry = 479;
`endif
    for (int y = tly; y <= bry; y++) begin
      for (int x = tlx; x <= brx; x++) begin
        wr_t w;
        w.addr = 19'(y * 640 + x);
        w.data = op ? rom_val(17'(arg) + 17'(k)) : arg;
        exp_q.push_back(w);
        k++;
      end
    end
  endtask

  // Drives one command with gp_en held until gp_finish, then drops gp_en for one edge
  task automatic issue(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                       input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg,
                       output int fin_cyc, output logic fin_after_drop);
    int start_wr = wr_count;
    gp_opcode = op; gp_tl_x = tlx; gp_tl_y = tly; gp_br_x = brx; gp_br_y = bry; gp_arg = arg;
    gp_en = 1'b1;
    issue_cyc = cyc;
    first_we_cyc = -1;
    first_armed = 1'b1;
    fin_cyc = -1;
    for (int i = 1; i <= 20000; i++) begin
      @(posedge clk); #1;
      if (gp_finish) begin
        fin_cyc = i;
        break;
      end
    end
    gp_en = 1'b0;
    #1 fin_after_drop = gp_finish;
    @(posedge clk); #1;
    $display("cmd op=%0d (%0d,%0d)-(%0d,%0d) arg=%h finish_cycles=%0d writes=%0d",
             op, tlx, tly, brx, bry, arg, fin_cyc, wr_count - start_wr);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gp_finish, busy, vram_we} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got finish/busy/we=%b expected 000", {gp_finish, busy, vram_we});
    end
    checks++;
    if (vram_addr !== '0 || vram_data !== '0 || rom_addr !== '0) begin
      failures++;
      $display("FAIL reset_buses got vaddr=%0d vdata=%h raddr=%0d expected 0", vram_addr, vram_data, rom_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_small();
    int fc; logic fd;
    push_rect(1'b0, 351, 150, 353, 151, 12'hF9C);
    issue(1'b0, 10'd351, 9'd150, 10'd353, 9'd151, 12'hF9C, fc, fd);
    checks++;
    if (first_we_cyc - issue_cyc !== 2) begin
      failures++;
      $display("FAIL fill_latency got %0d expected 2", first_we_cyc - issue_cyc);
    end
    checks++;
    if (fc <= 0 || fd !== 1'b0) begin
      failures++;
      $display("FAIL fill_finish got cycles=%0d after_drop=%b expected finish then 0", fc, fd);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL fill_missing got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_idle_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_blit();
    int fc; logic fd;
    push_rect(1'b1, 0, 0, 1, 1, 12'h010);
    issue(1'b1, 10'd0, 9'd0, 10'd1, 9'd1, 12'h010, fc, fd);
    checks++;
    if (first_we_cyc - issue_cyc !== 3) begin
      failures++;
      $display("FAIL blit_latency got %0d expected 3", first_we_cyc - issue_cyc);
    end
    checks++;
    if (fc <= 0 || fd !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL blit_done got cycles=%0d after_drop=%b pending=%0d expected finish,0,0", fc, fd, exp_q.size());
    end
    push_rect(1'b1, 100, 200, 104, 202, 12'hFF0);
    issue(1'b1, 10'd100, 9'd200, 10'd104, 9'd202, 12'hFF0, fc, fd);
    checks++;
    if (fc <= 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL blit_5x3 got cycles=%0d pending=%0d expected finish,0", fc, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int fc1, fc2; logic fd1, fd2;
    push_rect(1'b0, 5, 7, 9, 8, 12'h0A5);
    push_rect(1'b0, 20, 30, 20, 30, 12'h5A0);
    issue(1'b0, 10'd5, 9'd7, 10'd9, 9'd8, 12'h0A5, fc1, fd1);
    issue(1'b0, 10'd20, 9'd30, 10'd20, 9'd30, 12'h5A0, fc2, fd2);
    checks++;
    if (fc1 <= 0 || fc2 <= 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back got cycles=%0d/%0d pending=%0d expected finish twice,0", fc1, fc2, exp_q.size());
    end
    checks++;
    if (first_we_cyc - issue_cyc !== 2) begin
      failures++;
      $display("FAIL one_pixel_latency got %0d expected 2", first_we_cyc - issue_cyc);
    end
  endtask

  task automatic test_corner_fill();
    int fc; logic fd;
    int start_wr = wr_count;
    push_rect(1'b0, 600, 470, 639, 479, 12'hFFF);
    issue(1'b0, 10'd600, 9'd470, 10'd639, 9'd479, 12'hFFF, fc, fd);
    checks++;
    if (wr_count - start_wr != 400 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL corner_fill got writes=%0d pending=%0d expected 400,0", wr_count - start_wr, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int fc; logic fd;
    int start_wr = wr_count;
    bit reached = 1'b0;
    push_rect(1'b0, 0, 100, 63, 110, 12'h123);
    gp_opcode = 1'b0; gp_tl_x = 10'd0; gp_tl_y = 9'd100; gp_br_x = 10'd63; gp_br_y = 9'd110;
    gp_arg = 12'h123; gp_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (wr_count - start_wr >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL abort_progress got %0d writes expected 10", wr_count - start_wr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (vram_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got we=%b busy=%b expected 0 0", vram_we, busy);
    end
    exp_q.delete();
    gp_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    push_rect(1'b0, 33, 44, 35, 44, 12'h777);
    issue(1'b0, 10'd33, 9'd44, 10'd35, 9'd44, 12'h777, fc, fd);
    checks++;
    if (fc <= 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_abort got cycles=%0d pending=%0d expected finish,0", fc, exp_q.size());
    end
  endtask

`ifdef GRAPHICS_PAINTER_CLIP_EN
  task automatic test_clip();
    int fc; logic fd;
    int start_wr = wr_count;
    push_rect(1'b0, 630, 470, 700, 500, 12'h0F0);
    issue(1'b0, 10'd630, 9'd470, 10'd700, 9'd500, 12'h0F0, fc, fd);
    checks++;
    if (wr_count - start_wr != 100 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clip_count got writes=%0d pending=%0d expected 100,0", wr_count - start_wr, exp_q.size());
    end
    start_wr = wr_count;
    issue(1'b0, 10'd10, 9'd5, 10'd5, 9'd5, 12'hABC, fc, fd);
    checks++;
    if (wr_count != start_wr || fc <= 0 || fc > 2) begin
      failures++;
      $display("FAIL clip_empty got writes=%0d cycles=%0d expected 0 writes within 2", wr_count - start_wr, fc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_small();
    test_blit();
    test_back_to_back();
    test_corner_fill();
    test_reset_abort();
`ifdef GRAPHICS_PAINTER_CLIP_EN
    test_clip();
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
